// File: rtl/seq_det_ctrl_if.sv
// Bus bundle for the programmable sequence-detection controller: config port,
// session control, qualified serial input and match/status outputs.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic             xin;
  logic             xin_valid;
  logic             y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;

  // Host / serial source side
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    output start, stop, xin, xin_valid,
    input  cfg_err, y, busy, done, match_count
  );

  // Detector side
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    input  start, stop, xin, xin_valid,
    output cfg_err, y, busy, done, match_count
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with IDLE/SCAN/DONE session control,
// run-time pattern/length/overlap/limit configuration and a saturating match counter.
module seq_det_ctrl #(
  parameter int               PAT_W       = 8,
  parameter int               LEN_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(3'b110),
  parameter logic [LEN_W-1:0] DEF_LEN     = LEN_W'(3)
) (
  input  logic             clk,
  input  logic             reset,
  seq_det_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_nxt;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] lim_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;
  logic             cfg_err_q;

  logic             scanning;
  logic             restart;
  logic             scan_bit;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             lim_hit;
  logic             len_legal;
  logic             cfg_ok;

  assign scanning  = (state_q == S_SCAN);
  assign restart   = bus.start && !scanning;
  // stop beats a coincident valid bit: that bit is dropped and cannot match
  assign scan_bit  = scanning && bus.xin_valid && !bus.stop;
  assign hist_nxt  = {hist_q[PAT_W-2:0], bus.xin};
  assign fill_inc  = (fill_q == PAT_LEN) ? fill_q : fill_q + LEN_W'(1);
  assign hit       = scan_bit && (fill_inc >= len_q) &&
                     (((hist_nxt ^ pat_q) & len_mask(len_q)) == '0);
  assign cnt_inc   = sat_inc(cnt_q);
  assign lim_hit   = hit && (lim_q != '0) && (cnt_inc == lim_q);
  assign len_legal = (bus.cfg_len != '0) && (bus.cfg_len <= PAT_LEN);
  assign cfg_ok    = bus.cfg_we && !scanning && len_legal;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_nxt = S_SCAN;
      S_SCAN:  if (bus.stop || lim_hit) state_nxt = S_DONE;
      S_DONE:  if (bus.start) state_nxt = S_SCAN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= DEF_PATTERN;
      len_q     <= DEF_LEN;
      ovl_q     <= 1'b1;
      lim_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      y_q       <= hit;
      cfg_err_q <= bus.cfg_we && !cfg_ok;

      if (cfg_ok) begin
        pat_q <= bus.cfg_pattern;
        len_q <= bus.cfg_len;
        ovl_q <= bus.cfg_overlap;
        lim_q <= bus.cfg_limit;
      end

      // Non-overlapping mode restarts the fill so the next match needs len fresh bits
      if (restart) begin
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end else if (hit) begin
        hist_q <= hist_nxt;
        fill_q <= ovl_q ? fill_inc : '0;
        cnt_q  <= cnt_inc;
      end else if (scan_bit) begin
        hist_q <= hist_nxt;
        fill_q <= fill_inc;
      end
    end
  end

  assign bus.y           = y_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.busy        = (state_q == S_SCAN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized traffic, each cycle
// compared against a bit-list reference model of the detector's session rules.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: session phase, config, and the bits seen since the
  // last session start or non-overlapping match.
  int      m_phase;          // 0 idle, 1 scanning, 2 done
  int      m_pat, m_len, m_lim, m_cnt;
  bit      m_ovl;
  bit      seg[$];
  bit      e_y, e_err;

  task automatic model_reset();
    m_phase = 0; m_pat = 'b110; m_len = 3; m_ovl = 1; m_lim = 0; m_cnt = 0;
    seg.delete(); e_y = 0; e_err = 0;
  endtask

  function automatic bit model_matches();
    if (seg.size() < m_len) return 0;
    for (int k = 0; k < m_len; k++)
      if (seg[seg.size() - 1 - k] != m_pat[k]) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit xv, input bit x,
                            input bit we, input int pat, input int len, input bit ovl,
                            input int lim);
    bit was_scanning;
    was_scanning = (m_phase == 1);
    e_y = 0;
    e_err = 0;
    if (m_phase == 1) begin
      if (sp) m_phase = 2;
      else if (xv) begin
        seg.push_back(x);
        if (seg.size() > PAT_W) void'(seg.pop_front());
        if (model_matches()) begin
          e_y = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) seg.delete();
          if (m_lim != 0 && m_cnt == m_lim) m_phase = 2;
        end
      end
    end else if (st) begin
      m_phase = 1;
      m_cnt = 0;
      seg.delete();
    end
    if (we) begin
      if (!was_scanning && len >= 1 && len <= PAT_W) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_lim = lim;
      end else e_err = 1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},       int'(bus.y),           int'(e_y));
    check({tag, ".busy"},    int'(bus.busy),        int'(m_phase == 1));
    check({tag, ".done"},    int'(bus.done),        int'(m_phase == 2));
    check({tag, ".count"},   int'(bus.match_count), m_cnt);
    check({tag, ".cfg_err"}, int'(bus.cfg_err),     int'(e_err));
  endtask

  task automatic drive(input string tag, input bit st, input bit sp, input bit xv,
                       input bit x, input bit we, input int pat, input int len,
                       input bit ovl, input int lim);
    bus.start = st; bus.stop = sp; bus.xin_valid = xv; bus.xin = x;
    bus.cfg_we = we; bus.cfg_pattern = PAT_W'(pat); bus.cfg_len = LEN_W'(len);
    bus.cfg_overlap = ovl; bus.cfg_limit = CNT_W'(lim);
    model_step(st, sp, xv, x, we, pat, len, ovl, lim);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);        drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic bit_in(input string tag, input bit x); drive(tag, 0, 0, 1, x, 0, 0, 0, 0, 0); endtask
  task automatic start_s(input string tag);     drive(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic stop_s(input string tag);      drive(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wcfg(input string tag, input int pat, input int len, input bit ovl,
                      input int lim);
    drive(tag, 0, 0, 0, 0, 1, pat, len, ovl, lim);
  endtask

  task automatic bits(input string tag, input int val, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(tag, val[i]);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    bus.start = 0; bus.stop = 0; bus.xin_valid = 0; bus.xin = 0; bus.cfg_we = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    reset = 1;
    bus.start = 0; bus.stop = 0; bus.xin_valid = 0; bus.xin = 0; bus.cfg_we = 0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cfg_limit = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check("reset.y", int'(bus.y), 0);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.done", int'(bus.done), 0);
    check("reset.count", int'(bus.match_count), 0);
    check("reset.cfg_err", int'(bus.cfg_err), 0);

    // Default pattern 110 with overlap, stream 110110
    start_s("t1");
    bits("t1", 'b110110, 6);
    check("t1.final_count", int'(bus.match_count), 2);

    // 1010 overlapping, then non-overlapping, over 1010101
    stop_s("t2");
    wcfg("t2", 'b1010, 4, 1, 0);
    start_s("t2a");
    bits("t2a", 'b1010101, 7);
    check("t2a.final_count", int'(bus.match_count), 2);
    stop_s("t2");
    wcfg("t2", 'b1010, 4, 0, 0);
    start_s("t2b");
    bits("t2b", 'b1010101, 7);
    check("t2b.final_count", int'(bus.match_count), 1);

    // Limit of 2 on pattern 11 ends the session on the third bit
    stop_s("t3");
    wcfg("t3", 'b11, 2, 1, 2);
    start_s("t3");
    bits("t3", 'b1111, 4);
    check("t3.final_count", int'(bus.match_count), 2);
    check("t3.final_done", int'(bus.done), 1);

    // Illegal lengths and a write while busy are rejected
    do_reset("t4.rst");
    wcfg("t4.len0", 'b01, 0, 1, 0);
    idle("t4.after0");
    wcfg("t4.len9", 'b01, 9, 1, 0);
    start_s("t4");
    wcfg("t4.busy", 'b01, 2, 1, 0);
    bits("t4", 'b110, 3);
    check("t4.final_count", int'(bus.match_count), 1);

    // stop coincident with the completing bit
    do_reset("t5.rst");
    start_s("t5");
    bits("t5", 'b11011, 5);
    drive("t5.stopbit", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("t5.count_held", int'(bus.match_count), 1);
    check("t5.done", int'(bus.done), 1);
    start_s("t5.restart");
    check("t5.restart_count", int'(bus.match_count), 0);
    check("t5.restart_busy", int'(bus.busy), 1);

    // Reset with a partial 11 in history, then a lone 0 must not match
    bits("t6", 'b11, 2);
    do_reset("t6.rst");
    start_s("t6");
    bit_in("t6.zero", 0);
    check("t6.no_match", int'(bus.y), 0);
    idle("t6.idle");

    // Randomized sessions and interleaved control
    for (int s = 0; s < 12; s++) begin
      stop_s("rnd.stop");
      wcfg("rnd.cfg", int'($urandom_range(0, 255)), int'($urandom_range(1, 4)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      start_s("rnd.start");
      for (int c = 0; c < 80; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 2)
          drive("rnd.ctl", 1, 0, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        else if (r < 4)
          drive("rnd.stopx", 0, 1, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        else if (r < 7)
          drive("rnd.we", 0, 0, 1, 1'($urandom_range(0, 1)), 1,
                int'($urandom_range(0, 255)), int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
        else if (r < 8)
          do_reset("rnd.rst");
        else
          drive("rnd.bit", 0, 0, r < 85, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
